// File: rtl/fetch_stream_buffer.sv
// fetch_stream_buffer
//   Byte-stream instruction fetch buffer for the Y86-64 fetch stage. Memory
//   beats of up to IN_BYTES bytes are queued in a DEPTH-byte circular buffer.
//   Once a complete instruction sits at the head, it is presented to decode,
//   already split into fields, through a valid/ready handshake.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   flush, flush_pc     redirect: drop buffered bytes, restart at flush_pc
//   in_valid/in_ready   input beat handshake (ready means a full beat fits)
//   in_data, in_count   beat bytes (byte 0 in [7:0]) and number valid
//   out_valid/out_ready decoded instruction handshake
//   icode, ifun, rA, rB, valC, valP, pc_out   decoded instruction fields
//   instr_err           head byte carries an undefined icode
//   halted              a halt instruction has been consumed
module fetch_stream_buffer #(
  parameter int IN_BYTES = 2,
  parameter int DEPTH    = 16,
  parameter int PC_W     = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [PC_W-1:0]                flush_pc,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [8*IN_BYTES-1:0]          in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0]  in_count,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     icode,
  output logic [3:0]                     ifun,
  output logic [3:0]                     rA,
  output logic [3:0]                     rB,
  output logic [63:0]                    valC,
  output logic [PC_W-1:0]                valP,
  output logic [PC_W-1:0]                pc_out,
  output logic                           instr_err,
  output logic                           halted
);

  localparam int CW = $clog2(DEPTH + 1);     // occupancy width, holds 0..DEPTH
  localparam int HW = $clog2(DEPTH);         // buffer index width
  localparam int IW = $clog2(IN_BYTES + 1);  // in_count width

  // Pointer sums are carried one bit wider than the occupancy so that
  // head + count + k never overflows before the modulo-DEPTH fold.
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW:0]   INB_X   = (CW+1)'(IN_BYTES);
  localparam logic [IW-1:0] INB_I   = IW'(IN_BYTES);

  typedef enum logic [1:0] {RUN, HALTED, ERROR} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [HW-1:0]   head;
  logic [CW-1:0]   count;
  logic [PC_W-1:0] pc;

  logic [7:0]      win [10];
  logic [3:0]      len;
  logic            need_regids;
  logic            need_valc;
  logic            err_raw;
  logic            push;
  logic            pop;
  logic [CW:0]     wbase;
  logic [CW:0]     cnt_sum;

  // Every caller keeps sum below 2*DEPTH, so one conditional subtract folds it.
  function automatic logic [HW-1:0] wrap_idx(input logic [CW:0] sum);
    logic [CW:0] r;
    r = (sum >= DEPTH_X) ? (sum - DEPTH_X) : sum;
    return r[HW-1:0];
  endfunction

  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'h0, 4'h1, 4'h9:        instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  instr_len = 4'd2;
      4'h7, 4'h8:              instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:        instr_len = 4'd10;
      default:                 instr_len = 4'd1;
    endcase
  endfunction

  // Window of the ten bytes starting at head; the longest instruction is ten.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      win[k] = mem[wrap_idx((CW+1)'(head) + (CW+1)'(k))];
    end
  end

  always_comb begin
    icode       = win[0][7:4];
    ifun        = win[0][3:0];
    len         = instr_len(win[0][7:4]);
    err_raw     = (win[0][7:4] > 4'hB);
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (win[0][7:4])
      4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      4'h7, 4'h8:             need_valc   = 1'b1;
      default: ;
    endcase
    rA   = need_regids ? win[1][7:4] : 4'hF;
    rB   = need_regids ? win[1][3:0] : 4'hF;
    valC = 64'd0;
    if (need_valc) begin
      if (need_regids) valC = {win[9], win[8], win[7], win[6], win[5], win[4], win[3], win[2]};
      else             valC = {win[8], win[7], win[6], win[5], win[4], win[3], win[2], win[1]};
    end
    valP   = pc + PC_W'(len);
    pc_out = pc;
  end

  // Handshake outputs depend only on registered state, never on in/out inputs.
  always_comb begin
    in_ready  = (state == RUN) && (({1'b0, count} + INB_X) <= DEPTH_X);
    out_valid = (state == RUN) && (count != '0) && (count >= CW'(len));
    halted    = (state == HALTED);
    instr_err = err_raw && (count != '0);
  end

  // A beat with a zero or oversize byte count is ignored entirely.
  assign push  = in_valid && in_ready && (in_count != '0) && (in_count <= INB_I);
  assign pop   = out_valid && out_ready;
  assign wbase = (CW+1)'(head) + {1'b0, count};

  always_comb begin
    cnt_sum = {1'b0, count};
    if (push) cnt_sum = cnt_sum + (CW+1)'(in_count);
    if (pop)  cnt_sum = cnt_sum - (CW+1)'(len);
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else if (pop) begin
      if (win[0][7:4] == 4'h0) state_nxt = HALTED;
      else if (err_raw)        state_nxt = ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      pc    <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      pc    <= flush_pc;
    end else begin
      count <= cnt_sum[CW-1:0];
      if (pop) begin
        head <= wrap_idx((CW+1)'(head) + (CW+1)'(len));
        pc   <= pc + PC_W'(len);
      end
    end
  end

  // Byte storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      for (int k = 0; k < IN_BYTES; k++) begin
        if (k < int'(in_count)) mem[wrap_idx(wbase + (CW+1)'(k))] <= in_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fetch_stream_buffer.sv
module tb_fetch_stream_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic [1:0]  in_count = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic        instr_err, halted;

  int checks = 0;
  int errors = 0;

  fetch_stream_buffer #(.IN_BYTES(2), .DEPTH(16), .PC_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .pc_out(pc_out), .instr_err(instr_err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] c);
    in_valid = 1'b1; in_data = d; in_count = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %0b want 0", halted); end
    checks++; if (instr_err !== 1'b0) begin errors++; $display("FAIL rst_instr_err: got %0b want 0", instr_err); end
    checks++; if (pc_out !== 64'd0) begin errors++; $display("FAIL rst_pc: got %0h want 0", pc_out); end
  endtask

  task automatic test_long_instr();
    logic [15:0] beats [5];
    beats[0] = 16'hF330; beats[1] = 16'h0001; beats[2] = 16'h0000;
    beats[3] = 16'h0000; beats[4] = 16'h0000;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(beats[i], 2'd2);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL long_early_valid beat %0d: got %0b want 0", i, out_valid); end
    end
    push(beats[4], 2'd2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL long_valid: got %0b want 1", out_valid); end
    checks++; if (icode !== 4'h3 || ifun !== 4'h0) begin errors++; $display("FAIL long_icode: got %h%h want 30", icode, ifun); end
    checks++; if (rA !== 4'hF || rB !== 4'h3) begin errors++; $display("FAIL long_regs: got %h %h want f 3", rA, rB); end
    checks++; if (valC !== 64'd1) begin errors++; $display("FAIL long_valC: got %0h want 1", valC); end
    checks++; if (valP !== 64'd10 || pc_out !== 64'd0) begin errors++; $display("FAIL long_pc: got valP %0h pc %0h want a 0", valP, pc_out); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL long_drain: got valid %0b ready %0b want 0 1", out_valid, in_ready); end
    push(16'h0010, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h1 || pc_out !== 64'd10) begin errors++; $display("FAIL long_after: got v%0b ic %h pc %0h want v1 ic 1 pc a", out_valid, icode, pc_out); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    push(16'h0010, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h1 || pc_out !== 64'd0 || valP !== 64'd1) begin errors++; $display("FAIL stream_nop: got v%0b ic %h pc %0h valP %0h want v1 ic 1 pc 0 valP 1", out_valid, icode, pc_out, valP); end
    checks++; if (rA !== 4'hF || rB !== 4'hF) begin errors++; $display("FAIL stream_nop_regs: got %h %h want f f", rA, rB); end
    push(16'h1260, 2'd2);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h6 || pc_out !== 64'd1 || valP !== 64'd3) begin errors++; $display("FAIL stream_opq: got v%0b ic %h pc %0h valP %0h want v1 ic 6 pc 1 valP 3", out_valid, icode, pc_out, valP); end
    checks++; if (rA !== 4'h1 || rB !== 4'h2) begin errors++; $display("FAIL stream_opq_regs: got %h %h want 1 2", rA, rB); end
    push(16'h0090, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h9 || pc_out !== 64'd3 || valP !== 64'd4) begin errors++; $display("FAIL stream_ret: got v%0b ic %h pc %0h valP %0h want v1 ic 9 pc 3 valP 4", out_valid, icode, pc_out, valP); end
    checks++; if (rA !== 4'hF || rB !== 4'hF) begin errors++; $display("FAIL stream_ret_regs: got %h %h want f f", rA, rB); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    do_reset();
    out_ready = 1'b0;
    push(16'h1260, 2'd2);
    for (int i = 0; i < 6; i++) push(16'h1010, 2'd2);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_14_ready: got %0b want 1", in_ready); end
    push(16'h0010, 2'd1);
    in_valid = 1'b1; in_data = 16'h1010; in_count = 2'd2;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_15_ready cyc %0d: got %0b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || icode !== 4'h6 || rA !== 4'h1 || rB !== 4'h2 || pc_out !== 64'd0 || valP !== 64'd2) begin errors++; $display("FAIL full_hold cyc %0d: got v%0b ic %h rA %h rB %h pc %0h valP %0h", i, out_valid, icode, rA, rB, pc_out, valP); end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %0b want 1", in_ready); end
    checks++; if (pc_out !== 64'd2 || icode !== 4'h1) begin errors++; $display("FAIL full_after_pop_head: got pc %0h ic %h want 2 1", pc_out, icode); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    push(16'h1260, 2'd2);
    push(16'h1010, 2'd2);
    in_valid = 1'b1; in_data = 16'h3420; in_count = 2'd2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (pc_out !== 64'd2 || icode !== 4'h1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_head: got pc %0h ic %h rdy %0b want 2 1 1", pc_out, icode, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || pc_out !== 64'd3 || icode !== 4'h1) begin errors++; $display("FAIL b2b_nop2: got v%0b pc %0h ic %h want 1 3 1", out_valid, pc_out, icode); end
    tick();
    checks++; if (out_valid !== 1'b1 || icode !== 4'h2 || rA !== 4'h3 || rB !== 4'h4 || pc_out !== 64'd4 || valP !== 64'd6) begin errors++; $display("FAIL b2b_rrmov: got v%0b ic %h rA %h rB %h pc %0h valP %0h", out_valid, icode, rA, rB, pc_out, valP); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_count4: got valid %0b want 0", out_valid); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(16'h1010, 2'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || pc_out !== 64'd12) begin errors++; $display("FAIL wrap_pre: got v%0b pc %0h want 0 c", out_valid, pc_out); end
    push(16'h8870, 2'd2);
    push(16'h6677, 2'd2);
    push(16'h4455, 2'd2);
    push(16'h2233, 2'd2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_partial: got %0b want 0", out_valid); end
    push(16'h0011, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h7 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'hF) begin errors++; $display("FAIL wrap_jmp: got v%0b ic %h fn %h rA %h rB %h", out_valid, icode, ifun, rA, rB); end
    checks++; if (valC !== 64'h1122334455667788) begin errors++; $display("FAIL wrap_valC: got %h want 1122334455667788", valC); end
    checks++; if (pc_out !== 64'd12 || valP !== 64'd21) begin errors++; $display("FAIL wrap_pc: got pc %0h valP %0h want c 15", pc_out, valP); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || pc_out !== 64'd21) begin errors++; $display("FAIL wrap_drain: got v%0b pc %0h want 0 15", out_valid, pc_out); end
  endtask

  task automatic test_halt_error();
    do_reset();
    out_ready = 1'b0;
    push(16'hE000, 2'd2);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h0 || valP !== 64'd1 || instr_err !== 1'b0) begin errors++; $display("FAIL halt_pres: got v%0b ic %h valP %0h err %0b", out_valid, icode, valP, instr_err); end
    out_ready = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_state: got h%0b v%0b r%0b want 1 0 0", halted, out_valid, in_ready); end
    tick();
    checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky: got h%0b v%0b want 1 0", halted, out_valid); end
    flush = 1'b1; flush_pc = 64'h100; out_ready = 1'b0;
    tick();
    flush = 1'b0;
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || pc_out !== 64'h100) begin errors++; $display("FAIL halt_flush: got h%0b r%0b v%0b pc %0h want 0 1 0 100", halted, in_ready, out_valid, pc_out); end
    push(16'h00E0, 2'd1);
    checks++; if (out_valid !== 1'b1 || instr_err !== 1'b1 || icode !== 4'hE || valP !== 64'h101) begin errors++; $display("FAIL err_pres: got v%0b err %0b ic %h valP %0h want 1 1 e 101", out_valid, instr_err, icode, valP); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL err_state: got v%0b r%0b h%0b want 0 0 0", out_valid, in_ready, halted); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    out_ready = 1'b0;
    push(16'h1010, 2'd2);
    flush = 1'b1; flush_pc = 64'h40;
    in_valid = 1'b1; in_data = 16'h3420; in_count = 2'd2; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || pc_out !== 64'h40 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_prio: got v%0b pc %0h r%0b want 0 40 1", out_valid, pc_out, in_ready); end
    push(16'h0010, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h1 || pc_out !== 64'h40 || valP !== 64'h41) begin errors++; $display("FAIL flush_next: got v%0b ic %h pc %0h valP %0h want 1 1 40 41", out_valid, icode, pc_out, valP); end
    push(16'hF330, 2'd2);
    push(16'h0001, 2'd2);
    do_reset();
    checks++; if (out_valid !== 1'b0 || pc_out !== 64'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset: got v%0b pc %0h r%0b want 0 0 1", out_valid, pc_out, in_ready); end
    push(16'h0010, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h1 || pc_out !== 64'd0 || valP !== 64'd1) begin errors++; $display("FAIL midreset_next: got v%0b ic %h pc %0h valP %0h want 1 1 0 1", out_valid, icode, pc_out, valP); end
  endtask

  task automatic test_bad_count();
    do_reset();
    out_ready = 1'b0;
    push(16'h0010, 2'd0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL badcnt_zero: got %0b want 0", out_valid); end
    push(16'h1010, 2'd3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL badcnt_over: got %0b want 0", out_valid); end
    push(16'h0060, 2'd1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL badcnt_partial: got %0b want 0", out_valid); end
    push(16'h0012, 2'd1);
    checks++; if (out_valid !== 1'b1 || icode !== 4'h6 || rA !== 4'h1 || rB !== 4'h2 || pc_out !== 64'd0) begin errors++; $display("FAIL badcnt_next: got v%0b ic %h rA %h rB %h pc %0h", out_valid, icode, rA, rB, pc_out); end
  endtask

  initial begin
    test_reset();
    test_long_instr();
    test_stream();
    test_full_stall();
    test_back_to_back();
    test_halt_error();
    test_flush_reset();
    test_bad_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
